// File: rtl/intersection_model_pkg.sv
// Shared types and constants for the intersection model: light colours, lane indices,
// legal non-red lane groups and the per-lane debug state.
package light_package;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } colors;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    FLOW  = 2'd2
  } lane_state;

  localparam int NUM_LANES = 5;
  localparam int LANE_ES   = 0;
  localparam int LANE_WS   = 1;
  localparam int LANE_EL   = 2;
  localparam int LANE_WL   = 3;
  localparam int LANE_NS   = 4;

  localparam logic [4:0] GROUP_EW_STR = 5'b00011;
  localparam logic [4:0] GROUP_EAST   = 5'b00101;
  localparam logic [4:0] GROUP_WEST   = 5'b01010;
  localparam logic [4:0] GROUP_LEFTS  = 5'b01100;
  localparam logic [4:0] GROUP_NS     = 5'b10000;

  // A non-red mask is legal when it fits entirely inside one group; all-red fits every group.
  function automatic logic mask_is_legal(input logic [4:0] mask);
    mask_is_legal = ((mask & ~GROUP_EW_STR) == 5'd0) ||
                    ((mask & ~GROUP_EAST)   == 5'd0) ||
                    ((mask & ~GROUP_WEST)   == 5'd0) ||
                    ((mask & ~GROUP_LEFTS)  == 5'd0) ||
                    ((mask & ~GROUP_NS)     == 5'd0);
  endfunction

endpackage

// File: rtl/intersection_model_checker.sv
// Consistency properties over the per-lane debug state of the intersection model.
module intersection_model_checker
  import light_package::*;
#(
  parameter int QCNT_W = 4
) (
  input logic              clk,
  input logic              reset,
  input logic [4:0]        green,
  input logic [QCNT_W-1:0] count [NUM_LANES],
  input lane_state         state [NUM_LANES]
);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane_chk
    a_empty_matches_count : assert property (@(posedge clk) disable iff (reset)
      (state[i] == EMPTY) == (count[i] == {QCNT_W{1'b0}}));
    a_flow_needs_green : assert property (@(posedge clk) disable iff (reset)
      (state[i] == FLOW) |-> green[i]);
  end

endmodule

// File: rtl/intersection_model_lane_queue.sv
// One lane of the intersection: vehicle counter fed by arrival pulses and drained
// one vehicle per gap interval while the lane light is green.
module lane_queue
  import light_package::*;
#(
  parameter int QCNT_W     = 4,
  parameter int DEPART_GAP = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arrive,
  input  logic              green,
  output logic [QCNT_W-1:0] count,
  output logic              departed,
  output logic              overflow,
  output lane_state         state
);

  localparam logic [QCNT_W-1:0] CNT_ZERO = {QCNT_W{1'b0}};
  localparam logic [QCNT_W-1:0] CNT_ONE  = {{(QCNT_W-1){1'b0}}, 1'b1};
  localparam logic [QCNT_W-1:0] CNT_FULL = {QCNT_W{1'b1}};
  localparam logic [3:0]        GAP_LOAD = 4'(DEPART_GAP - 1);

  logic [QCNT_W-1:0] count_r;
  logic [3:0]        gap_r;
  logic              overflow_r;
  logic              depart_s;
  lane_state         state_s;

  // The departure strobe is combinational so the count and the top-level total move on the same edge.
  assign depart_s = green && (count_r != CNT_ZERO) && (gap_r == 4'd0);

  // Queue count with sticky overflow; a simultaneous arrival and departure cancel out, even when full.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r    <= CNT_ZERO;
      overflow_r <= 1'b0;
    end else begin
      case ({arrive, depart_s})
        2'b10: begin
          if (count_r == CNT_FULL) begin
            overflow_r <= 1'b1;
          end else begin
            count_r <= count_r + CNT_ONE;
          end
        end
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Spacing between departures; cleared off-green so the first green cycle may depart.
  always_ff @(posedge clk) begin
    if (reset) begin
      gap_r <= 4'd0;
    end else if (!green) begin
      gap_r <= 4'd0;
    end else if (depart_s) begin
      gap_r <= GAP_LOAD;
    end else if (gap_r != 4'd0) begin
      gap_r <= gap_r - 4'd1;
    end else begin
      gap_r <= gap_r;
    end
  end

  // Debug classification of the lane.
  always_comb begin
    state_s = EMPTY;
    if (count_r == CNT_ZERO) begin
      state_s = EMPTY;
    end else if (green) begin
      state_s = FLOW;
    end else begin
      state_s = WAIT;
    end
  end

  assign count    = count_r;
  assign departed = depart_s;
  assign overflow = overflow_r;
  assign state    = state_s;

endmodule

// File: rtl/intersection_model.sv
// Five-lane intersection model closing the loop around the light controller.
// Build option INTERSECTION_CONFLICT_CHECK_EN compiles in the illegal-light monitor.
module intersection_model
  import light_package::*;
#(
  parameter int QCNT_W     = 4,
  parameter int DEPART_GAP = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  arrive,
  input  colors       e_str_light,
  input  colors       w_str_light,
  input  colors       e_left_light,
  input  colors       w_left_light,
  input  colors       ns_light,
  output logic        e_str_sensor,
  output logic        w_str_sensor,
  output logic        e_left_sensor,
  output logic        w_left_sensor,
  output logic        ns_sensor,
  output logic [15:0] departed_total,
  output logic [4:0]  overflow,
  output logic        conflict,
  output logic [4:0]  conflict_lanes
);

  colors             light_s [NUM_LANES];
  logic [4:0]        green_s;
  logic [4:0]        departed_s;
  logic [4:0]        overflow_s;
  logic [4:0]        sensor_s;
  logic [2:0]        dep_sum_s;
  logic [15:0]       total_r;
  logic [QCNT_W-1:0] count_s [NUM_LANES];
  lane_state         state_s [NUM_LANES];

  assign light_s[LANE_ES] = e_str_light;
  assign light_s[LANE_WS] = w_str_light;
  assign light_s[LANE_EL] = e_left_light;
  assign light_s[LANE_WL] = w_left_light;
  assign light_s[LANE_NS] = ns_light;

  // Green decode per lane.
  always_comb begin
    green_s = 5'd0;
    for (int i = 0; i < NUM_LANES; i++) begin
      green_s[i] = (light_s[i] == GREEN);
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_queue #(
      .QCNT_W     (QCNT_W),
      .DEPART_GAP (DEPART_GAP)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .arrive   (arrive[i]),
      .green    (green_s[i]),
      .count    (count_s[i]),
      .departed (departed_s[i]),
      .overflow (overflow_s[i]),
      .state    (state_s[i])
    );
    assign sensor_s[i] = (count_s[i] != {QCNT_W{1'b0}});
  end

  // Number of lanes departing this cycle.
  always_comb begin
    dep_sum_s = 3'd0;
    for (int i = 0; i < NUM_LANES; i++) begin
      dep_sum_s = dep_sum_s + {2'b00, departed_s[i]};
    end
  end

  // Running departure total, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      total_r <= 16'd0;
    end else begin
      total_r <= total_r + {13'd0, dep_sum_s};
    end
  end

`ifdef INTERSECTION_CONFLICT_CHECK_EN
  logic [4:0] nonred_s;
  logic       conflict_r;
  logic [4:0] conflict_lanes_r;

  // Non-red mask: yellow still occupies the junction.
  always_comb begin
    nonred_s = 5'd0;
    for (int i = 0; i < NUM_LANES; i++) begin
      nonred_s[i] = (light_s[i] != RED);
    end
  end

  // Sticky flag keeps the first offending mask for post-mortem.
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_r       <= 1'b0;
      conflict_lanes_r <= 5'd0;
    end else if (!conflict_r && !mask_is_legal(nonred_s)) begin
      conflict_r       <= 1'b1;
      conflict_lanes_r <= nonred_s;
    end else begin
      conflict_r       <= conflict_r;
      conflict_lanes_r <= conflict_lanes_r;
    end
  end

  assign conflict       = conflict_r;
  assign conflict_lanes = conflict_lanes_r;
`else
  assign conflict       = 1'b0;
  assign conflict_lanes = 5'd0;
`endif

  intersection_model_checker #(
    .QCNT_W (QCNT_W)
  ) u_checker (
    .clk   (clk),
    .reset (reset),
    .green (green_s),
    .count (count_s),
    .state (state_s)
  );

  assign e_str_sensor   = sensor_s[LANE_ES];
  assign w_str_sensor   = sensor_s[LANE_WS];
  assign e_left_sensor  = sensor_s[LANE_EL];
  assign w_left_sensor  = sensor_s[LANE_WL];
  assign ns_sensor      = sensor_s[LANE_NS];
  assign departed_total = total_r;
  assign overflow       = overflow_s;

endmodule

// File: tb/tb_intersection_model.sv
// Scoreboard bench for intersection_model: a cycle model pushes expected outputs,
// each scenario task pops and compares them against what the DUT produced.
module tb_intersection_model;
  import light_package::*;

  localparam int GAP = 2;
  localparam int CAP = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  arrive;
  colors       lt [5];
  logic        e_str_sensor, w_str_sensor, e_left_sensor, w_left_sensor, ns_sensor;
  logic [15:0] departed_total;
  logic [4:0]  overflow;
  logic        conflict;
  logic [4:0]  conflict_lanes;
  logic [4:0]  sens_obs;

  int          m_cnt [5];
  int          m_gap [5];
  logic [4:0]  m_ovf;
  logic [15:0] m_total;
  logic        m_conf;
  logic [4:0]  m_clanes;
  logic [31:0] exp_q [$];
  logic [31:0] act_q [$];
  logic [31:0] e, a;
  int          checks = 0;
  int          errors = 0;

  intersection_model #(.QCNT_W(4), .DEPART_GAP(GAP)) dut (
    .clk            (clk),
    .reset          (reset),
    .arrive         (arrive),
    .e_str_light    (lt[0]),
    .w_str_light    (lt[1]),
    .e_left_light   (lt[2]),
    .w_left_light   (lt[3]),
    .ns_light       (lt[4]),
    .e_str_sensor   (e_str_sensor),
    .w_str_sensor   (w_str_sensor),
    .e_left_sensor  (e_left_sensor),
    .w_left_sensor  (w_left_sensor),
    .ns_sensor      (ns_sensor),
    .departed_total (departed_total),
    .overflow       (overflow),
    .conflict       (conflict),
    .conflict_lanes (conflict_lanes)
  );

  always #5 clk = ~clk;

  assign sens_obs = {ns_sensor, w_left_sensor, e_left_sensor, w_str_sensor, e_str_sensor};

  // Advance the model one cycle from the current inputs, push its prediction, clock the DUT.
  task automatic step();
    logic [4:0] nonred;
    logic [4:0] es;
    logic       legal;
    logic       g, dep;
    int         ndep;
    if (reset) begin
      for (int i = 0; i < 5; i++) begin
        m_cnt[i] = 0;
        m_gap[i] = 0;
      end
      m_ovf = 5'd0; m_total = 16'd0; m_conf = 1'b0; m_clanes = 5'd0;
    end else begin
      ndep = 0;
      nonred = 5'd0;
      for (int i = 0; i < 5; i++) begin
        g = (lt[i] == GREEN);
        nonred[i] = (lt[i] != RED);
        dep = g && (m_cnt[i] > 0) && (m_gap[i] == 0);
        if (dep) ndep++;
        if (arrive[i] && !dep) begin
          if (m_cnt[i] == CAP) m_ovf[i] = 1'b1;
          else m_cnt[i]++;
        end else if (!arrive[i] && dep) begin
          m_cnt[i]--;
        end
        if (!g) m_gap[i] = 0;
        else if (dep) m_gap[i] = GAP - 1;
        else if (m_gap[i] > 0) m_gap[i]--;
      end
      m_total = m_total + 16'(ndep);
`ifdef INTERSECTION_CONFLICT_CHECK_EN
      legal = ((nonred & 5'b11100) == 5'd0) || ((nonred & 5'b11010) == 5'd0) ||
              ((nonred & 5'b10101) == 5'd0) || ((nonred & 5'b10011) == 5'd0) ||
              ((nonred & 5'b01111) == 5'd0);
      if (!legal && !m_conf) begin
        m_conf = 1'b1;
        m_clanes = nonred;
      end
`else
      legal = 1'b1;
`endif
    end
    for (int i = 0; i < 5; i++) es[i] = (m_cnt[i] != 0);
    exp_q.push_back({es, m_ovf, m_conf, m_clanes, m_total});
    @(posedge clk);
    #1;
    act_q.push_back({sens_obs, overflow, conflict, conflict_lanes, departed_total});
  endtask

  task automatic all_red();
    for (int i = 0; i < 5; i++) lt[i] = RED;
  endtask

  task automatic test_reset();
    reset = 1'b1; arrive = 5'd0; all_red();
    step(); step();
    checks++;
    if ({sens_obs, overflow, conflict, conflict_lanes, departed_total} !== 32'd0) begin
      errors++;
      $display("FAIL reset_state got %h expected %h",
               {sens_obs, overflow, conflict, conflict_lanes, departed_total}, 32'd0);
    end
    reset = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL reset_sb got %h expected %h", a, e); end
    end
  endtask

  task automatic test_arrivals();
    for (int k = 0; k < 3; k++) begin
      arrive = 5'b00001; step();
      arrive = 5'b00000; step();
    end
    checks++;
    if (sens_obs !== 5'b00001) begin errors++; $display("FAIL arr_sensors got %b expected %b", sens_obs, 5'b00001); end
    checks++;
    if (departed_total !== 16'd0) begin errors++; $display("FAIL arr_total got %0d expected 0", departed_total); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL arr_sb got %h expected %h", a, e); end
    end
  endtask

  task automatic test_departures();
    logic [15:0] want [6];
    want[0] = 16'd1; want[1] = 16'd1; want[2] = 16'd2;
    want[3] = 16'd2; want[4] = 16'd3; want[5] = 16'd3;
    lt[0] = GREEN;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (departed_total !== want[k]) begin
        errors++; $display("FAIL dep_cycle%0d got %0d expected %0d", k, departed_total, want[k]);
      end
    end
    checks++;
    if (e_str_sensor !== 1'b0) begin errors++; $display("FAIL dep_sensor got %b expected 0", e_str_sensor); end
    all_red(); step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL dep_sb got %h expected %h", a, e); end
    end
  endtask

  task automatic test_overflow();
    arrive = 5'b10000;
    for (int k = 0; k < 16; k++) step();
    checks++;
    if (overflow !== 5'b10000) begin errors++; $display("FAIL ovf_flag got %b expected %b", overflow, 5'b10000); end
    lt[4] = GREEN;
    step();
    arrive = 5'd0;
    checks++;
    if (departed_total !== 16'd4 || ns_sensor !== 1'b1) begin
      errors++; $display("FAIL ovf_simul got total %0d sensor %b expected 4 1", departed_total, ns_sensor);
    end
    for (int k = 0; k < 32; k++) step();
    checks++;
    if (departed_total !== 16'd19 || ns_sensor !== 1'b0) begin
      errors++; $display("FAIL ovf_drain got total %0d sensor %b expected 19 0", departed_total, ns_sensor);
    end
    all_red(); step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL ovf_sb got %h expected %h", a, e); end
    end
  endtask

  task automatic test_yellow_cutoff();
    arrive = 5'b00010;
    for (int k = 0; k < 5; k++) step();
    arrive = 5'd0;
    lt[1] = GREEN; step();
    lt[1] = YELLOW; step(); step(); step();
    lt[1] = RED; step(); step(); step();
    checks++;
    if (departed_total !== 16'd20 || w_str_sensor !== 1'b1) begin
      errors++; $display("FAIL yel_one got total %0d sensor %b expected 20 1", departed_total, w_str_sensor);
    end
    lt[1] = GREEN;
    for (int k = 0; k < 10; k++) step();
    checks++;
    if (departed_total !== 16'd24 || w_str_sensor !== 1'b0) begin
      errors++; $display("FAIL yel_rest got total %0d sensor %b expected 24 0", departed_total, w_str_sensor);
    end
    all_red(); step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL yel_sb got %h expected %h", a, e); end
    end
  endtask

  task automatic test_conflict();
    logic       want_c;
    logic [4:0] want_l;
`ifdef INTERSECTION_CONFLICT_CHECK_EN
    want_c = 1'b1; want_l = 5'b10001;
`else
    want_c = 1'b0; want_l = 5'b00000;
`endif
    lt[0] = GREEN; lt[2] = GREEN;
    step(); step(); step();
    checks++;
    if (conflict !== 1'b0) begin errors++; $display("FAIL cfl_legal got %b expected 0", conflict); end
    all_red(); lt[4] = GREEN; lt[0] = YELLOW;
    step();
    checks++;
    if (conflict !== want_c || conflict_lanes !== want_l) begin
      errors++; $display("FAIL cfl_set got %b %b expected %b %b", conflict, conflict_lanes, want_c, want_l);
    end
    all_red(); lt[1] = GREEN; lt[3] = GREEN;
    step(); step();
    checks++;
    if (conflict !== want_c || conflict_lanes !== want_l) begin
      errors++; $display("FAIL cfl_hold got %b %b expected %b %b", conflict, conflict_lanes, want_c, want_l);
    end
    all_red(); step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL cfl_sb got %h expected %h", a, e); end
    end
  endtask

  task automatic test_mid_reset();
    arrive = 5'b11111; step(); step();
    arrive = 5'd0; lt[0] = GREEN; lt[1] = GREEN; step();
    reset = 1'b1; arrive = 5'b11111;
    step();
    checks++;
    if ({sens_obs, overflow, conflict, conflict_lanes, departed_total} !== 32'd0) begin
      errors++;
      $display("FAIL midrst got %h expected %h",
               {sens_obs, overflow, conflict, conflict_lanes, departed_total}, 32'd0);
    end
    reset = 1'b0; arrive = 5'd0; all_red(); step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL midrst_sb got %h expected %h", a, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] groups [5];
    logic [4:0] mask;
    groups[0] = 5'b00011; groups[1] = 5'b00101; groups[2] = 5'b01010;
    groups[3] = 5'b01100; groups[4] = 5'b10000;
    for (int k = 0; k < 400; k++) begin
      arrive = 5'($urandom) & 5'($urandom);
      mask = ($urandom_range(0, 9) == 0) ? 5'b11111 : groups[$urandom_range(0, 4)];
      for (int i = 0; i < 5; i++)
        lt[i] = mask[i] ? colors'(2'($urandom_range(0, 2))) : RED;
      reset = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0; arrive = 5'd0; all_red();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL b2b_sb got %h expected %h", a, e); end
    end
  endtask

  initial begin
    reset = 1'b1;
    arrive = 5'd0;
    all_red();
    test_reset();
    test_arrivals();
    test_departures();
    test_overflow();
    test_yellow_cutoff();
    test_conflict();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
